// File: rtl/ysyx_24100027_alu_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two
// requesters: accept, one EXEC cycle, then hold the response until consumed.
module ysyx_24100027_alu_arb #(
    parameter int DW  = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           r0_req_valid,
    output logic           r0_req_ready,
    input  logic [DW-1:0]  r0_a,
    input  logic [DW-1:0]  r0_b,
    input  logic [OPW-1:0] r0_op,
    output logic           r0_resp_valid,
    input  logic           r0_resp_ready,
    input  logic           r1_req_valid,
    output logic           r1_req_ready,
    input  logic [DW-1:0]  r1_a,
    input  logic [DW-1:0]  r1_b,
    input  logic [OPW-1:0] r1_op,
    output logic           r1_resp_valid,
    input  logic           r1_resp_ready,
    output logic [DW-1:0]  resp_result,
    output logic [3:0]     resp_flags,
    output logic           resp_err,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_ctrl,
    input  logic [DW-1:0]  alu_result,
    input  logic [3:0]     alu_flags,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic           op_inv_q, op_inv_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DW-1:0]  resp_result_q, resp_result_d;
    logic [3:0]     resp_flags_q, resp_flags_d;
    logic           resp_err_q, resp_err_d;
    logic           r0_resp_valid_q, r0_resp_valid_d;
    logic           r1_resp_valid_q, r1_resp_valid_d;

    logic           gnt_vld;
    logic           gnt_id;
    logic           accept;
    logic           resp_hs;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [OPW-1:0] sel_op;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_vld = r0_req_valid | r1_req_valid;
        if (r0_req_valid && r1_req_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = r1_req_valid;
        end
    end

    assign accept       = (state_q == IDLE) && gnt_vld;
    assign r0_req_ready = accept && !gnt_id;
    assign r1_req_ready = accept && gnt_id;

    assign sel_a  = gnt_id ? r1_a  : r0_a;
    assign sel_b  = gnt_id ? r1_b  : r0_b;
    assign sel_op = gnt_id ? r1_op : r0_op;

    assign resp_hs = owner_q ? (r1_resp_valid_q && r1_resp_ready)
                             : (r0_resp_valid_q && r0_resp_ready);

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        op_inv_d        = op_inv_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_ctrl_d      = alu_ctrl_q;
        resp_result_d   = resp_result_q;
        resp_flags_d    = resp_flags_q;
        resp_err_d      = resp_err_q;
        r0_resp_valid_d = r0_resp_valid_q;
        r1_resp_valid_d = r1_resp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    op_inv_d     = sel_op[OPW-1];
                    // Invalid codes never reach the ALU.
                    alu_ctrl_d   = sel_op[OPW-1] ? '0 : sel_op;
                    owner_d      = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (op_inv_q) begin
                    resp_result_d = '0;
                    resp_flags_d  = '0;
                    resp_err_d    = 1'b1;
                end else begin
                    resp_result_d = alu_result;
                    resp_flags_d  = alu_flags;
                    resp_err_d    = 1'b0;
                end
                r0_resp_valid_d = !owner_q;
                r1_resp_valid_d = owner_q;
                state_d         = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    r0_resp_valid_d = 1'b0;
                    r1_resp_valid_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: begin
                r0_resp_valid_d = 1'b0;
                r1_resp_valid_d = 1'b0;
                state_d         = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            op_inv_q        <= 1'b0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_ctrl_q      <= '0;
            resp_result_q   <= '0;
            resp_flags_q    <= '0;
            resp_err_q      <= 1'b0;
            r0_resp_valid_q <= 1'b0;
            r1_resp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            op_inv_q        <= op_inv_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_ctrl_q      <= alu_ctrl_d;
            resp_result_q   <= resp_result_d;
            resp_flags_q    <= resp_flags_d;
            resp_err_q      <= resp_err_d;
            r0_resp_valid_q <= r0_resp_valid_d;
            r1_resp_valid_q <= r1_resp_valid_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign resp_result   = resp_result_q;
    assign resp_flags    = resp_flags_q;
    assign resp_err      = resp_err_q;
    assign r0_resp_valid = r0_resp_valid_q;
    assign r1_resp_valid = r1_resp_valid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_24100027_alu_arb.sv
// Bench for ysyx_24100027_alu_arb: behavioural ALU, directed requests,
// expected responses queued at accept and popped by a response monitor.
module tb_ysyx_24100027_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
    logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]  r0_op, r1_op;
    logic [31:0] resp_result, alu_a, alu_b, alu_result;
    logic [3:0]  resp_flags, alu_flags;
    logic        resp_err, busy;
    logic [2:0]  alu_ctrl;

    always #5 clk = ~clk;

    ysyx_24100027_alu_arb #(.DW(32), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
    );

    // Behavioural ALU; cf is carry-out, so a sub without borrow sets cf.
    logic [32:0] s;
    logic        ovf;
    always_comb begin
        s   = '0;
        ovf = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                s   = {1'b0, alu_a} + {1'b0, alu_b};
                ovf = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
            end
            3'b001: begin
                s   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                ovf = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
            end
            3'b010: s = {1'b0, alu_a ^ alu_b};
            3'b011: s = {1'b0, alu_a | alu_b};
            default: s = '0;
        endcase
        alu_result = s[31:0];
        alu_flags  = {ovf, s[31:0] == 32'd0, s[31], s[32]};
    end

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic pop(input logic p);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=resp_on_r%0d required=none", p);
        end else begin
            e = sbq.pop_front();
            chk("resp_owner", {31'd0, p}, {31'd0, e.owner});
            chk("resp_result", resp_result, e.res);
            chk("resp_flags", {28'd0, resp_flags}, {28'd0, e.flg});
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (r0_resp_valid || r1_resp_valid)
                chk("resp_onehot", {31'd0, r0_resp_valid & r1_resp_valid}, 32'd0);
            if (r0_resp_valid && r0_resp_ready) pop(1'b0);
            if (r1_resp_valid && r1_resp_ready) pop(1'b1);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic req(input logic p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] er,
                       input logic [3:0] ef, input logic ee, input bit push);
        bit done = 0;
        if (!p) begin
            r0_a = a; r0_b = b; r0_op = op; r0_req_valid = 1'b1;
        end else begin
            r1_a = a; r1_b = b; r1_op = op; r1_req_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((!p && r0_req_ready) || (p && r1_req_ready)) begin
                done = 1;
                if (push) sbq.push_back('{p, er, ef, ee});
                glog.push_back(int'(p));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout_r%0d actual=no_ready required=ready", p);
        end
        @(posedge clk);
        #1;
        if (!p) r0_req_valid = 1'b0;
        else    r1_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && !r0_resp_valid && !r1_resp_valid) break;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        r0_req_valid = 0; r1_req_valid = 0;
        r0_a = 0; r0_b = 0; r0_op = 0;
        r1_a = 0; r1_b = 0; r1_op = 0;
        r0_resp_ready = 1; r1_resp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r0_resp_valid", {31'd0, r0_resp_valid}, 32'd0);
        chk("rst_r1_resp_valid", {31'd0, r1_resp_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_flags", {28'd0, resp_flags}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;

        // Single add on r0 with latency checks
        req(0, 32'd5, 32'd3, 3'b000, 32'd8, 4'b0000, 0, 1);
        @(negedge clk);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_r0_resp_valid", {31'd0, r0_resp_valid}, 32'd0);
        chk("exec_alu_a", alu_a, 32'd5);
        chk("exec_alu_b", alu_b, 32'd3);
        @(negedge clk);
        chk("lat_r0_resp_valid", {31'd0, r0_resp_valid}, 32'd1);
        chk("lat_r1_resp_valid", {31'd0, r1_resp_valid}, 32'd0);
        wait_idle();

        req(1, 32'd7, 32'd7, 3'b001, 32'd0, 4'b0101, 0, 1);
        wait_idle();
        req(0, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 4'b1010, 0, 1);
        wait_idle();

        // Fairness with both requesters continuously valid
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        glog.delete();
        fork
            begin
                req(0, 32'd1, 32'd2, 3'b000, 32'd3, 4'b0000, 0, 1);
                req(0, 32'hFF, 32'hFF, 3'b010, 32'd0, 4'b0100, 0, 1);
                req(0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 4'b0101, 0, 1);
                req(0, 32'd0, 32'd0, 3'b011, 32'd0, 4'b0100, 0, 1);
            end
            begin
                req(1, 32'hF0, 32'h0F, 3'b011, 32'hFF, 4'b0000, 0, 1);
                req(1, 32'd1, 32'd2, 3'b001, 32'hFFFF_FFFF, 4'b0010, 0, 1);
                req(1, 32'h8000_0000, 32'd0, 3'b010, 32'h8000_0000, 4'b0010, 0, 1);
                req(1, 32'h8000_0000, 32'd1, 3'b001, 32'h7FFF_FFFF, 4'b1001, 0, 1);
            end
        join
        wait_idle();
        chk("grant_count", glog.size(), 32'd8);
        for (int i = 0; i < glog.size(); i++)
            chk($sformatf("grant_order_%0d", i), glog[i], i % 2);

        // Response backpressure with r1 waiting
        r0_resp_ready = 0;
        req(0, 32'hA, 32'h5, 3'b010, 32'hF, 4'b0000, 0, 1);
        fork
            req(1, 32'h10, 32'h1, 3'b001, 32'hF, 4'b0001, 0, 1);
        join_none
        @(negedge clk);
        chk("bp_exec_r1_ready", {31'd0, r1_req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_r0_resp_valid", {31'd0, r0_resp_valid}, 32'd1);
            chk("bp_result_hold", resp_result, 32'hF);
            chk("bp_flags_hold", {28'd0, resp_flags}, 32'd0);
            chk("bp_r1_req_ready", {31'd0, r1_req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 r0_resp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_r1_granted", {31'd0, r1_req_ready}, 32'd1);
        wait fork;
        wait_idle();

        // Invalid opcode
        req(0, 32'd1, 32'd2, 3'b101, 32'd0, 4'b0000, 1, 1);
        @(negedge clk);
        chk("inv_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("inv_alu_a", alu_a, 32'd1);
        @(negedge clk);
        chk("inv_lat_resp_valid", {31'd0, r0_resp_valid}, 32'd1);
        chk("inv_err", {31'd0, resp_err}, 32'd1);
        wait_idle();

        // Reset while in EXEC drops the operation
        req(0, 32'd9, 32'd9, 3'b000, 32'd0, 4'b0000, 0, 0);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, resp_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_no_resp", {31'd0, r0_resp_valid | r1_resp_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        glog.delete();
        fork
            req(0, 32'd2, 32'd2, 3'b001, 32'd0, 4'b0101, 0, 1);
            req(1, 32'd3, 32'd4, 3'b011, 32'd7, 4'b0000, 0, 1);
        join
        wait_idle();
        chk("post_rst_first_grant", glog[0], 32'd0);
        chk("post_rst_second_grant", glog[1], 32'd1);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
